// File: rtl/nim_turn_ctrl.sv
// rtl/nim_turn_ctrl.sv - two-player Nim turn controller with BCD pile and score pulses
module nim_turn_ctrl #(
  parameter int MAX_TAKE = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       take,
  input  logic       pass,
  input  logic [3:0] init_tens,
  input  logic [3:0] init_ones,
  output logic [3:0] pile_tens,
  output logic [3:0] pile_ones,
  output logic       player,
  output logic [1:0] taken_cnt,
  output logic       game_over,
  output logic       winner,
  output logic       inc_left,
  output logic       inc_right
);

  typedef enum logic [1:0] {IDLE, TURN, WIN} state_t;

  localparam logic [1:0] MAX_TAKE_C = 2'(MAX_TAKE);

  state_t     state_q, state_d;
  logic       start_prev_q, take_prev_q, pass_prev_q;
  // High for the first cycle after reset so a button held through release
  // is captured as the previous level instead of being seen as a new press.
  logic       rst_mask_q;
  logic [3:0] tens_q, tens_d;
  logic [3:0] ones_q, ones_d;
  logic       player_q, player_d;
  logic [1:0] taken_q, taken_d;
  logic       game_over_q, game_over_d;
  logic       winner_q, winner_d;
  logic       inc_left_q, inc_left_d;
  logic       inc_right_q, inc_right_d;
  logic       next_first_q, next_first_d;

  logic       start_ev, take_ev, pass_ev;
  logic [3:0] ld_tens, ld_ones;
  logic [3:0] dec_tens, dec_ones;
  logic [1:0] taken_inc;

  assign start_ev  = start & ~start_prev_q & ~rst_mask_q;
  assign take_ev   = take  & ~take_prev_q  & ~rst_mask_q;
  assign pass_ev   = pass  & ~pass_prev_q  & ~rst_mask_q;

  assign ld_tens   = (init_tens > 4'd9) ? 4'd9 : init_tens;
  assign ld_ones   = (init_ones > 4'd9) ? 4'd9 : init_ones;

  assign dec_ones  = (ones_q == 4'd0) ? 4'd9 : (ones_q - 4'd1);
  assign dec_tens  = (ones_q == 4'd0) ? (tens_q - 4'd1) : tens_q;
  assign taken_inc = taken_q + 2'd1;

  // Next-state and registered-output decode; take wins over a same-cycle pass.
  always_comb begin
    state_d      = state_q;
    tens_d       = tens_q;
    ones_d       = ones_q;
    player_d     = player_q;
    taken_d      = taken_q;
    game_over_d  = game_over_q;
    winner_d     = winner_q;
    inc_left_d   = 1'b0;
    inc_right_d  = 1'b0;
    next_first_d = next_first_q;

    case (state_q)
      IDLE, WIN: begin
        if (start_ev) begin
          taken_d     = 2'd0;
          game_over_d = 1'b0;
          if ((ld_tens == 4'd0) && (ld_ones == 4'd0)) begin
            tens_d  = 4'd0;
            ones_d  = 4'd0;
            state_d = IDLE;
          end else begin
            tens_d       = ld_tens;
            ones_d       = ld_ones;
            player_d     = next_first_q;
            next_first_d = ~next_first_q;
            state_d      = TURN;
          end
        end
      end
      TURN: begin
        if (take_ev) begin
          tens_d = dec_tens;
          ones_d = dec_ones;
          if ((dec_tens == 4'd0) && (dec_ones == 4'd0)) begin
            state_d     = WIN;
            game_over_d = 1'b1;
            winner_d    = player_q;
            inc_left_d  = ~player_q;
            inc_right_d = player_q;
            taken_d     = 2'd0;
          end else if (taken_inc == MAX_TAKE_C) begin
            player_d = ~player_q;
            taken_d  = 2'd0;
          end else begin
            taken_d = taken_inc;
          end
        end else if (pass_ev && (taken_q != 2'd0)) begin
          player_d = ~player_q;
          taken_d  = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, edge-detect and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      start_prev_q <= 1'b0;
      take_prev_q  <= 1'b0;
      pass_prev_q  <= 1'b0;
      rst_mask_q   <= 1'b1;
      tens_q       <= 4'd0;
      ones_q       <= 4'd0;
      player_q     <= 1'b0;
      taken_q      <= 2'd0;
      game_over_q  <= 1'b0;
      winner_q     <= 1'b0;
      inc_left_q   <= 1'b0;
      inc_right_q  <= 1'b0;
      next_first_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      start_prev_q <= start;
      take_prev_q  <= take;
      pass_prev_q  <= pass;
      rst_mask_q   <= 1'b0;
      tens_q       <= tens_d;
      ones_q       <= ones_d;
      player_q     <= player_d;
      taken_q      <= taken_d;
      game_over_q  <= game_over_d;
      winner_q     <= winner_d;
      inc_left_q   <= inc_left_d;
      inc_right_q  <= inc_right_d;
      next_first_q <= next_first_d;
    end
  end

  assign pile_tens = tens_q;
  assign pile_ones = ones_q;
  assign player    = player_q;
  assign taken_cnt = taken_q;
  assign game_over = game_over_q;
  assign winner    = winner_q;
  assign inc_left  = inc_left_q;
  assign inc_right = inc_right_q;

endmodule
